// File: rtl/fix_to_single.sv
// rtl/fix_to_single.sv - signed fixed-point to IEEE-754 single converter, one normalising shift per clock
module fix_to_single #(
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24,
    localparam int W          = INT_WIDTH + FRACT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] fixed_point,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  single
);

    // Exponent of a magnitude whose MSB sits at bit W-1 before any shift.
    localparam int EXP_BIAS = 127 + W - 1 - FRACT_WIDTH;
    localparam int SHW      = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic           sign;
    logic           zero;
    logic [W-1:0]   mag;
    logic [SHW-1:0] sh;

    logic [W-1:0]   fx_abs;
    logic [W+22:0]  mant_src;
    logic [22:0]    mant;
    logic           guard;
    logic           sticky;
    logic           round_up;
    logic [23:0]    mant_rnd;
    logic           carry;
    logic [22:0]    mant_out;
    logic [7:0]     exp_fin;

    // Magnitude of the incoming word; the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign fx_abs = fixed_point[W-1] ? (~fixed_point + W'(1)) : fixed_point;

    // Fraction bits below the hidden one, zero-padded so narrow words still yield 23 mantissa bits plus guard.
    assign mant_src = {mag[W-2:0], 24'd0};
    assign mant     = mant_src[W+22 -: 23];
    assign guard    = mant_src[W-1];
    assign sticky   = |mant_src[W-2:0];
    assign round_up = guard && (sticky || mant[0]);

    // Round to nearest even; a carry out of the mantissa bumps the exponent and clears the fraction.
    assign mant_rnd = {1'b0, mant} + {23'd0, round_up};
    assign carry    = mant_rnd[23];
    assign mant_out = carry ? 23'd0 : mant_rnd[22:0];
    assign exp_fin  = 8'(EXP_BIAS) - {1'b0, sh} + {7'd0, carry};

    // Control FSM: capture, normalise one bit per cycle, round, then hold the result until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sign      <= 1'b0;
            zero      <= 1'b0;
            mag       <= '0;
            sh        <= '0;
            single    <= 32'h0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign     <= fixed_point[W-1];
                        mag      <= fx_abs;
                        sh       <= '0;
                        in_ready <= 1'b0;
                        if (fx_abs == '0) begin
                            zero  <= 1'b1;
                            state <= ROUND;
                        end else if (fx_abs[W-1]) begin
                            zero  <= 1'b0;
                            state <= ROUND;
                        end else begin
                            zero  <= 1'b0;
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[W-1]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        sh  <= sh + SHW'(1);
                        // The shift that lands the leading one in the MSB also ends normalisation.
                        if (mag[W-2]) begin
                            state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    single <= zero ? 32'h0 : {sign, exp_fin, mant_out};
                    state  <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_to_single.sv
// tb/tb_fix_to_single.sv - directed self-checking bench for fix_to_single
module tb_fix_to_single;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fixed_point;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] single;

    int errors = 0;
    int checks = 0;

    fix_to_single #(.INT_WIDTH(8), .FRACT_WIDTH(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fixed_point (fixed_point),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .single      (single)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a word, accept it, wait for the result, check latency/value, then drain it.
    task automatic convert(input string tag, input logic [31:0] word,
                           input logic [31:0] exp_single, input int exp_lat);
        int  lat;
        logic ready_low;
        fixed_point = word;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        lat       = 0;
        ready_low = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, {31'd0, ready_low}, 32'd1);
        chk({tag, "_single"}, single, exp_single);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int          lat;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        fixed_point = 32'h0;
        #12;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_single", single, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        convert("one",      32'h01000000, 32'h3F800000, 9);
        convert("neg1p5",   32'hFE800000, 32'hBFC00000, 9);
        convert("mostneg",  32'h80000000, 32'hC3000000, 2);
        convert("zero",     32'h00000000, 32'h00000000, 2);
        convert("tie_even", 32'h01000001, 32'h3F800000, 9);
        convert("tie_odd",  32'h01000003, 32'h3F800002, 9);
        convert("carry",    32'h7FFFFFFF, 32'h43000000, 3);

        // Backpressure: result held for 5 cycles, a stray input pulse must be ignored.
        fixed_point = 32'hFE800000;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        held = single;
        chk("bp_value", held, 32'hBFC00000);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                fixed_point = 32'h01000000;
                in_valid    = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_hold_single", single, held);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("bp_no_capture", {31'd0, out_valid}, 32'd0);
        end
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of normalisation.
        fixed_point = 32'h00000100;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("rst_mid_busy", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_single", single, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        convert("after_rst", 32'h01000000, 32'h3F800000, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
